// File: rtl/scroll_pkg.sv
// scroll_pkg: shared types, ring geometry and nibble selection for hex_scroll_window.
// Optional build macro: SCROLL_GAP_EN adds four blank gap positions to the ring.
package scroll_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    SCROLL = 2'd2
  } state_t;

  localparam int unsigned NIBBLES = 16;
  localparam int unsigned GAP     = 4;

`ifdef SCROLL_GAP_EN
  localparam int unsigned GAP_EN = 1;
`else
  localparam int unsigned GAP_EN = 0;
`endif

  // Number of window base positions; gap positions follow the 16 real digits.
  localparam int unsigned RING = NIBBLES + GAP_EN * GAP;
  localparam int unsigned PW   = $clog2(RING);

  // Nibble idx of a 64-bit number.
  function automatic logic [3:0] nib_sel(input logic [63:0] shadow, input logic [3:0] idx);
    return shadow[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/step_timer.sv
// step_timer: STEP_CYCLES prescaler for the scroll window.
// Ports: clk, reset (sync, active-low), en (count), clr (restart at 0),
//        tick_c (combinational: asserted on the last count of an interval while enabled).
module step_timer #(
  parameter int unsigned STEP_CYCLES = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned TW = $clog2(STEP_CYCLES);
  localparam logic [TW-1:0] LAST = TW'(STEP_CYCLES - 1);

  logic [TW-1:0] count;

  assign tick_c = en && (count == LAST);

  // Interval counter; holds its value while disabled so a pause resumes mid-interval.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clr || tick_c) begin
      count <= '0;
    end else if (en) begin
      count <= count + TW'(1);
    end
  end

endmodule

// File: rtl/hex_scroll_window.sv
// hex_scroll_window: captures a 64-bit hex number on load and scrolls a 4-digit
// window across its 16 nibbles, one position every STEP_CYCLES clocks.
// Ports: clk, reset (sync, active-low), load, number_in[63:0], run, dir
//        (0 = toward higher nibbles), win_d0..win_d3 (d0 rightmost), win_valid,
//        pos (window base), wrap (pulse after ring wrap), blank (SCROLL_GAP_EN only).
// Optional build macro: SCROLL_GAP_EN (20-position ring with 4 blank gap positions).
module hex_scroll_window
  import scroll_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 25_000_000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [63:0]   number_in,
  input  logic          run,
  input  logic          dir,
  output logic [3:0]    win_d0,
  output logic [3:0]    win_d1,
  output logic [3:0]    win_d2,
  output logic [3:0]    win_d3,
  output logic          win_valid,
  output logic [PW-1:0] pos,
  output logic          wrap
`ifdef SCROLL_GAP_EN
  ,
  output logic [3:0]    blank
`endif
);

  localparam int unsigned SW = PW + 1;

  state_t        state_q, state_d;
  logic [63:0]   shadow, shadow_d;
  logic [PW-1:0] pos_d;
  logic          valid_d;
  logic          wrap_d;
  logic [3:0]    win_n [4];
  logic [SW-1:0] sum;
  logic          timer_en;
  logic          step_tick;
`ifdef SCROLL_GAP_EN
  logic [3:0]    blank_n;
`endif

  // The HOLD->SCROLL transition cycle already counts, so a resume continues the interval at once.
  assign timer_en = run && (state_q != IDLE) && !load;

  step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_step_timer (
    .clk    (clk),
    .reset  (reset),
    .en     (timer_en),
    .clr    (load),
    .tick_c (step_tick)
  );

  // Next state, next position and next window contents.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow;
    pos_d    = pos;
    valid_d  = win_valid;
    wrap_d   = 1'b0;
    sum      = '0;
`ifdef SCROLL_GAP_EN
    blank_n  = '0;
`endif
    for (int i = 0; i < 4; i++) win_n[i] = '0;

    unique case (state_q)
      IDLE:    ;
      HOLD:    if (run)  state_d = SCROLL;
      SCROLL:  if (!run) state_d = HOLD;
      default: state_d = IDLE;
    endcase

    if (step_tick) begin
      if (dir) begin
        if (pos == '0) begin
          pos_d  = PW'(RING - 1);
          wrap_d = 1'b1;
        end else begin
          pos_d = pos - PW'(1);
        end
      end else begin
        if (pos == PW'(RING - 1)) begin
          pos_d  = '0;
          wrap_d = 1'b1;
        end else begin
          pos_d = pos + PW'(1);
        end
      end
    end

    // Load overrides any step in the same cycle.
    if (load) begin
      shadow_d = number_in;
      pos_d    = '0;
      valid_d  = 1'b1;
      wrap_d   = 1'b0;
      state_d  = run ? SCROLL : HOLD;
    end

    // Window is derived from the next position so pos and digits change on the same edge.
    for (int i = 0; i < 4; i++) begin
      sum = {1'b0, pos_d} + SW'(i);
      if (sum >= SW'(RING)) sum = sum - SW'(RING);
`ifdef SCROLL_GAP_EN
      if (sum >= SW'(NIBBLES)) begin
        blank_n[i] = 1'b1;
        win_n[i]   = '0;
      end else begin
        win_n[i] = valid_d ? nib_sel(shadow_d, sum[3:0]) : 4'h0;
      end
`else
      win_n[i] = valid_d ? nib_sel(shadow_d, sum[3:0]) : 4'h0;
`endif
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      shadow    <= '0;
      pos       <= '0;
      win_valid <= 1'b0;
      wrap      <= 1'b0;
      win_d0    <= '0;
      win_d1    <= '0;
      win_d2    <= '0;
      win_d3    <= '0;
`ifdef SCROLL_GAP_EN
      blank     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      shadow    <= shadow_d;
      pos       <= pos_d;
      win_valid <= valid_d;
      wrap      <= wrap_d;
      win_d0    <= win_n[0];
      win_d1    <= win_n[1];
      win_d2    <= win_n[2];
      win_d3    <= win_n[3];
`ifdef SCROLL_GAP_EN
      blank     <= blank_n;
`endif
    end
  end

endmodule

// File: tb/tb_hex_scroll_window.sv
// tb_hex_scroll_window: self-checking bench for hex_scroll_window with STEP_CYCLES=4.
// Optional build macro: SCROLL_GAP_EN (must match the RTL build).
module tb_hex_scroll_window;

  localparam int SC = 4;
  localparam logic [63:0] N = 64'h0123_4567_89AB_CDEF;
`ifdef SCROLL_GAP_EN
  localparam int RING_M = 20;
  localparam int PWB    = 5;
`else
  localparam int RING_M = 16;
  localparam int PWB    = 4;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           load = 1'b0;
  logic [63:0]    number_in = '0;
  logic           run = 1'b0;
  logic           dir = 1'b0;
  logic [3:0]     win_d0, win_d1, win_d2, win_d3;
  logic           win_valid;
  logic [PWB-1:0] pos;
  logic           wrap;
  logic [26:0]    obs;
`ifdef SCROLL_GAP_EN
  logic [3:0]     blank;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: 0 idle, 1 hold, 2 scroll
  int          m_mode = 0;
  int          m_pos = 0;
  int          m_timer = 0;
  logic [63:0] m_shadow = '0;
  bit          m_valid = 1'b0;
  bit          m_wrap = 1'b0;

  always #5 clk = ~clk;

  hex_scroll_window #(.STEP_CYCLES(SC)) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .number_in (number_in),
    .run       (run),
    .dir       (dir),
    .win_d0    (win_d0),
    .win_d1    (win_d1),
    .win_d2    (win_d2),
    .win_d3    (win_d3),
    .win_valid (win_valid),
    .pos       (pos),
    .wrap      (wrap)
`ifdef SCROLL_GAP_EN
    ,
    .blank     (blank)
`endif
  );

  // Observed vector: {blank, valid, wrap, pos[4:0], d3, d2, d1, d0}
`ifdef SCROLL_GAP_EN
  assign obs = {blank, win_valid, wrap, pos, win_d3, win_d2, win_d1, win_d0};
`else
  assign obs = {4'b0, win_valid, wrap, 1'b0, pos, win_d3, win_d2, win_d1, win_d0};
`endif

  function automatic void model_update();
    if (!reset) begin
      m_mode = 0; m_pos = 0; m_timer = 0; m_shadow = '0; m_valid = 1'b0; m_wrap = 1'b0;
    end else if (load) begin
      m_shadow = number_in; m_pos = 0; m_timer = 0; m_valid = 1'b1; m_wrap = 1'b0;
      m_mode = run ? 2 : 1;
    end else begin
      m_wrap = 1'b0;
      if (m_mode != 0) begin
        if (run) begin
          if (m_timer == SC - 1) begin
            m_timer = 0;
            if (dir) begin
              m_wrap = (m_pos == 0);
              m_pos  = (m_pos + RING_M - 1) % RING_M;
            end else begin
              m_wrap = (m_pos == RING_M - 1);
              m_pos  = (m_pos + 1) % RING_M;
            end
          end else begin
            m_timer = m_timer + 1;
          end
        end
        m_mode = run ? 2 : 1;
      end
    end
  endfunction

  function automatic logic [26:0] exp_vec();
    logic [15:0] d = '0;
    logic [3:0]  b = '0;
    int idx;
    for (int i = 0; i < 4; i++) begin
      idx = (m_pos + i) % RING_M;
      if (idx >= 16) b[i] = 1'b1;
      else if (m_valid) d[4*i +: 4] = 4'((m_shadow >> (4 * idx)) & 64'hF);
    end
    return {b, m_valid, m_wrap, 5'(m_pos), d};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    load = 1'b1;
    number_in = N;
    tick();
    tick();
    reset = 1'b1;
    load = 1'b0;
    n_checks++;
    if (obs !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", obs, 27'd0);
    end
    for (int k = 0; k < 10; k++) begin
      number_in = {$urandom, $urandom};
      run = 1'($urandom);
      dir = 1'($urandom);
      tick();
      n_checks++;
      if (obs !== 27'd0 || obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL idle_no_load: got %h expected %h", obs, 27'd0);
      end
    end
  endtask

  task automatic test_load_scroll();
    number_in = N;
    run = 1'b1;
    dir = 1'b0;
    load = 1'b1;
    tick();
    load = 1'b0;
    number_in = {$urandom, $urandom};
    n_checks++;
    if (obs[22:0] !== {1'b1, 1'b0, 5'd0, 16'hCDEF}) begin
      n_fail++;
      $display("FAIL load_window: got %h expected %h", obs[22:0], {1'b1, 1'b0, 5'd0, 16'hCDEF});
    end
    for (int k = 0; k < SC; k++) tick();
    n_checks++;
    if (obs[20:0] !== {5'd1, 16'hBCDE}) begin
      n_fail++;
      $display("FAIL first_step: got %h expected %h", obs[20:0], {5'd1, 16'hBCDE});
    end
    for (int k = 0; k < 200 && m_pos != 14; k++) begin
      tick();
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL scroll_up: got %h expected %h", obs, exp_vec());
      end
    end
    n_checks++;
`ifdef SCROLL_GAP_EN
    if (obs[26:0] !== {4'b1100, 1'b1, 1'b0, 5'd14, 16'h0001}) begin
      n_fail++;
      $display("FAIL pos14_window: got %h expected %h", obs, {4'b1100, 1'b1, 1'b0, 5'd14, 16'h0001});
    end
`else
    if (obs[26:0] !== {4'b0000, 1'b1, 1'b0, 5'd14, 16'hEF01}) begin
      n_fail++;
      $display("FAIL pos14_window: got %h expected %h", obs, {4'b0000, 1'b1, 1'b0, 5'd14, 16'hEF01});
    end
`endif
    for (int k = 0; k < 200 && m_pos != 0; k++) begin
      tick();
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL scroll_to_wrap: got %h expected %h", obs, exp_vec());
      end
      if (m_pos == 15) begin
        n_checks++;
        if (wrap !== 1'b0) begin
          n_fail++;
          $display("FAIL no_wrap_at_15: got %b expected 0", wrap);
        end
      end
    end
    n_checks++;
    if (wrap !== 1'b1 || m_pos != 0) begin
      n_fail++;
      $display("FAIL wrap_pulse: got wrap=%b pos=%0d expected wrap=1 pos=0", wrap, pos);
    end
    tick();
    n_checks++;
    if (wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_one_cycle: got %b expected 0", wrap);
    end
  endtask

  task automatic test_pause_reverse();
    int p0;
    for (int k = 0; k < 20 && m_timer != 2; k++) tick();
    p0 = m_pos;
    run = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_checks++;
      if (int'(pos) != p0 || obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL pause_hold: got pos=%0d expected %0d", pos, p0);
      end
    end
    run = 1'b1;
    tick();
    n_checks++;
    if (int'(pos) != p0) begin
      n_fail++;
      $display("FAIL resume_no_early_step: got pos=%0d expected %0d", pos, p0);
    end
    tick();
    n_checks++;
    if (int'(pos) != (p0 + 1) % RING_M) begin
      n_fail++;
      $display("FAIL resume_step: got pos=%0d expected %0d", pos, (p0 + 1) % RING_M);
    end
    for (int k = 0; k < 200 && m_pos != 0; k++) tick();
    dir = 1'b1;
    for (int k = 0; k < 2 * SC && m_pos == 0; k++) begin
      tick();
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL reverse_interval: got %h expected %h", obs, exp_vec());
      end
    end
    n_checks++;
`ifdef SCROLL_GAP_EN
    if (obs !== {4'b0001, 1'b1, 1'b1, 5'd19, 16'hDEF0}) begin
      n_fail++;
      $display("FAIL reverse_wrap: got %h expected %h", obs, {4'b0001, 1'b1, 1'b1, 5'd19, 16'hDEF0});
    end
`else
    if (obs !== {4'b0000, 1'b1, 1'b1, 5'd15, 16'hDEF0}) begin
      n_fail++;
      $display("FAIL reverse_wrap: got %h expected %h", obs, {4'b0000, 1'b1, 1'b1, 5'd15, 16'hDEF0});
    end
`endif
  endtask

  task automatic test_load_on_step();
    dir = 1'b0;
    run = 1'b1;
    for (int k = 0; k < 200 && !(m_pos == RING_M - 1 && m_timer == SC - 1); k++) tick();
    number_in = 64'hFFFF_0000_0000_1234;
    load = 1'b1;
    tick();
    load = 1'b0;
    n_checks++;
    if (obs !== {4'b0, 1'b1, 1'b0, 5'd0, 16'h1234}) begin
      n_fail++;
      $display("FAIL load_on_step: got %h expected %h", obs, {4'b0, 1'b1, 1'b0, 5'd0, 16'h1234});
    end
    tick();
    n_checks++;
    if (wrap !== 1'b0 || obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL load_on_step_no_wrap: got %h expected %h", obs, exp_vec());
    end
  endtask

  task automatic test_load_hold();
    run = 1'b0;
    number_in = {$urandom, $urandom};
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int k = 0; k < 10; k++) begin
      dir = 1'($urandom);
      tick();
      n_checks++;
      if (pos !== '0 || win_valid !== 1'b1 || obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL load_hold: got %h expected %h", obs, exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    run = 1'b1;
    dir = 1'b0;
    number_in = N;
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int k = 0; k < 200 && m_pos != 7; k++) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n_checks++;
    if (obs !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_mid_scroll: got %h expected %h", obs, 27'd0);
    end
    for (int k = 0; k < 2 * SC; k++) begin
      tick();
      n_checks++;
      if (obs !== 27'd0) begin
        n_fail++;
        $display("FAIL idle_after_reset: got %h expected %h", obs, 27'd0);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      reset = 1'($urandom_range(0, 149) != 0);
      load = 1'($urandom_range(0, 24) == 0);
      run = 1'($urandom_range(0, 3) != 0);
      dir = 1'($urandom);
      number_in = {$urandom, $urandom};
      tick();
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL random_model: got %h expected %h", obs, exp_vec());
      end
    end
    reset = 1'b1;
    load = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_load_scroll();
    test_pause_reverse();
    test_load_on_step();
    test_load_hold();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hex_scroll_window.md
Name: hex_scroll_window

Overview:
- Downstream consumer of the 64-bit hex number assembled by the input/loader stage.
- Captures that number on a load strobe, then presents a 4-nibble window of its 16 hex digits to the 4-digit seven-segment driver.
- Advances the window one digit every STEP_CYCLES clocks, with run/pause and direction control, so all 16 digits can be viewed on the 4-digit display.

Parameters:
- STEP_CYCLES, 25_000_000, clocks per scroll step (0.25 s at 100 MHz); must be >= 2.
- TW, $clog2(STEP_CYCLES), step-timer width; derived, not overridden.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- load  in  1  single-cycle strobe: capture number_in and restart at position 0
- number_in  in  64  hex number from the loader stage; nibble k = number_in[4k+3:4k]
- run  in  1  1 = scroll, 0 = hold the current window
- dir  in  1  0 = position increments (toward higher nibbles), 1 = decrements
- win_d0..win_d3  out  4 each  window digits, d0 rightmost; d_i = nibble (pos+i) mod 16
- win_valid  out  1  window holds captured data
- pos  out  4  (5 with SCROLL_GAP_EN)  current window base position
- wrap  out  1  one-cycle pulse when pos wraps around the ring
- blank  out  4  SCROLL_GAP_EN only: per-digit blank flags

Behaviour:
- Reset (reset==0 at a posedge) gives: state IDLE, shadow=0, pos=0, timer=0, win_d*=0, win_valid=0, wrap=0. A reset mid-scroll aborts the scroll immediately.
- All outputs are registered. Window registers update on the same edge as pos, so pos and win_d* always agree.
- States:
  - IDLE: win_valid=0; only load leaves this state.
  - HOLD: timer frozen, window static.
  - SCROLL: timer counts.
- load (any state):
  - Actions: shadow<=number_in, pos<=0, timer<=0, win_valid<=1.
  - Next state: SCROLL if run=1, else HOLD.
  - Window reflects the new number on the edge that samples load (1-cycle latency).
- SCROLL:
  - Timer increments each cycle. At timer==STEP_CYCLES-1: timer<=0 and pos steps by ±1 mod ring size per dir.
  - run==0 while in SCROLL moves to HOLD with the timer preserved, not cleared.
- HOLD: run==1 moves to SCROLL, resuming from the preserved timer value.
- dir is sampled only on the step cycle; changing it mid-interval affects only the next step.
- wrap is asserted for exactly the cycle after the step in which pos goes 15->0 (dir=0) or 0->15 (dir=1).
- Window indexing is modulo the ring size: (pos+i) wraps, so at pos=14 the digits are d0=n14, d1=n15, d2=n0, d3=n1.
- Simultaneous events:
  - load with a step: load wins; no step, no wrap.
  - load with run=0: goes to HOLD at pos 0.
- The number_in value between loads is ignored.

Optional Feature:
- Macro: SCROLL_GAP_EN.
- Defined:
  - Ring size is 20; positions 16..19 are blank gap positions and pos is 5 bits.
  - blank[i]=1 when (pos+i) mod 20 >= 16; win_d_i is then forced to 0.
  - wrap fires on 19->0 or 0->19.
- Undefined:
  - Ring size is 16 and pos is 4 bits.
  - The blank port does not exist.

Decomposition:
- Package scroll_pkg:
  - state enum {IDLE, HOLD, SCROLL}
  - NIBBLES=16, GAP=4
  - RING constant selected by SCROLL_GAP_EN
  - function nib_sel(shadow, idx) returning the 4-bit nibble
- One sub-module, step_timer: STEP_CYCLES prescaler with enable, clear and a tick output; instantiated once.

Test Plan (STEP_CYCLES=4, N=64'h0123_4567_89AB_CDEF):
- Reset then idle 10 cycles -> win_valid=0, win_d*=0, pos=0, wrap never asserted.
- load N with run=1, dir=0:
  - Next cycle: d3..d0 = C,D,E,F and pos=0.
  - After 4 cycles: pos=1 and d3..d0 = B,C,D,E.
- Continue to pos=14 -> d3..d0 = E,F,0,1. The step to pos=15 gives wrap=0; the step to 0 gives wrap=1 for exactly 1 cycle.
- Pause and reverse:
  - At timer=2, drop run for 10 cycles -> pos unchanged.
  - Raise run -> step occurs 2 cycles later.
  - Then dir=1 from pos=0 -> pos=15, wrap=1, d3..d0 = D,E,F,0.
- Assert load on the exact step cycle with number_in=64'hFFFF_0000_0000_1234 -> pos=0, d3..d0 = 1,2,3,4, no wrap.
- Assert reset mid-scroll at pos=7 -> next cycle all outputs return to reset values and the state is IDLE.
- SCROLL_GAP_EN: at pos=14 -> blank=4'b1100, d3=d2=0. Pos 19->0 pulses wrap.
